// File: rtl/nand_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial NAND adder.
// Controller state encoding and counter-width helper.
package nand_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/nand_fa_cell.sv
// One-bit full adder built only from nine 2-input NAND gates.
// Purely combinational; reused every cycle by the serial adder.
module nand_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, n4, n5, n6, n7;

    // First half adder yields a^b on n4; second folds in cin.
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign n4   = ~(n2 & n3);
    assign n5   = ~(n4 & cin);
    assign n6   = ~(n4 & n5);
    assign n7   = ~(cin & n5);
    assign sum  = ~(n6 & n7);
    assign cout = ~(n1 & n5);

endmodule

// File: rtl/nand_serial_adder.sv
// Bit-serial adder: one NAND full-adder cell iterated LSB-first over WIDTH bits.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds a 'sub' input for a - b.
module nand_serial_adder
    import nand_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] b_ld;
    logic             carry_ld;
    logic             fa_s;
    logic             fa_c;

    // Subtraction is a + ~b + 1, so only the loaded operand and carry change.
`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign b_ld     = sub ? ~b : b;
    assign carry_ld = sub ? 1'b1 : cin;
`else
    assign b_ld     = b;
    assign carry_ld = cin;
`endif

    nand_fa_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign a_d   = {1'b0, a_q[WIDTH-1:1]};
    assign b_d   = {1'b0, b_q[WIDTH-1:1]};
    assign res_d = {fa_s, res_q[WIDTH-1:1]};
    assign cnt_d = cnt_q + CW'(1);

    // Datapath registers are not reset; only control and visible outputs are.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= a;
                        b_q     <= b_ld;
                        carry_q <= carry_ld;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    res_q   <= res_d;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    sum_q   <= res_q;
                    cout_q  <= carry_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
